// File: rtl/audio_dac_pkg.sv
// Shared definitions for the audio DAC serializer: default sizing,
// synchronizer depth and the serializer state encoding.
package audio_dac_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_SAMPLE_BITS = 24;
    localparam int unsigned DEFAULT_FIFO_DEPTH  = 128;

    // Flip-flops in each codec clock synchronizer
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } ser_state_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock show-ahead FIFO holding packed stereo pairs.
// can_push is registered from the next-cycle occupancy so it is never stale.
module audio_sample_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   used,
    output logic                     empty,
    output logic                     can_push
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      used_next;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (used == FULL_CNT);
    assign empty   = (used == '0);
    assign do_push = push && !full  && !clear;
    assign do_pop  = pop  && !empty && !clear;
    assign rdata   = mem[rd_ptr];

    // Occupancy for the next cycle; clear overrides any push or pop
    always_comb begin
        used_next = used;
        if (clear) begin
            used_next = '0;
        end else if (do_push && !do_pop) begin
            used_next = used + ONE;
        end else if (!do_push && do_pop) begin
            used_next = used - ONE;
        end
    end

    // Pointers, count and the registered space-available flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            used     <= '0;
            can_push <= 1'b0;
        end else begin
            used     <= used_next;
            can_push <= (used_next != FULL_CNT);
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sample storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: buffers stereo pairs and shifts them MSB-first onto
// AUD_DACDAT, timed by codec-mastered BCLK/DACLRCK synchronized into CLOCK_50.
// Optional macro AUDIO_DAC_UNDERFLOW_HOLD_EN: on underflow repeat the last
// popped pair instead of sending silence.
module audio_dac_serializer
    import audio_dac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned SAMPLE_BITS = DEFAULT_SAMPLE_BITS,
    parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0]         left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0]         right_channel_audio_out,
    input  logic                          write_audio_out,
    output logic                          audio_out_allowed,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_used,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT
);

    localparam int unsigned CW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CW-1:0] BIT_LOAD = CW'(SAMPLE_BITS - 1);

    ser_state_t state, state_next;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
    logic                   bclk_prev, lrck_prev;
    logic                   bclk_fall, lrck_fall, lrck_rise;

    logic                    push, pop, fifo_empty;
    logic [2*DATA_WIDTH-1:0] fifo_rdata;
    logic                    frame_start, right_start;

    logic [SAMPLE_BITS-1:0] pop_left, pop_right;
    logic [SAMPLE_BITS-1:0] empty_left, empty_right;
    logic [SAMPLE_BITS-1:0] next_left, next_right;
    logic [SAMPLE_BITS-1:0] shift_word, right_word;
    logic [CW-1:0]          bit_cnt;
    logic                   slot_pending, active;
    logic                   unused_rdata;

    assign pop_left     = fifo_rdata[2*DATA_WIDTH-1 -: SAMPLE_BITS];
    assign pop_right    = fifo_rdata[DATA_WIDTH-1 -: SAMPLE_BITS];
    assign unused_rdata = ^fifo_rdata;
    assign push         = write_audio_out && audio_out_allowed;

    audio_sample_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .clear    (clear_audio_out_memory),
        .push     (push),
        .pop      (pop),
        .wdata    ({left_channel_audio_out, right_channel_audio_out}),
        .rdata    (fifo_rdata),
        .used     (fifo_used),
        .empty    (fifo_empty),
        .can_push (audio_out_allowed)
    );

    // Two-stage synchronizers plus a history bit for edge detection
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            lrck_prev <= lrck_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_fall = bclk_prev  && !bclk_sync[SYNC_STAGES-1];
    assign lrck_fall = lrck_prev  && !lrck_sync[SYNC_STAGES-1];
    assign lrck_rise = !lrck_prev &&  lrck_sync[SYNC_STAGES-1];

    // Serializer state register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Channel sequencing follows the frame clock
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lrck_fall) state_next = LEFT;
            LEFT:    if (lrck_rise) state_next = RIGHT;
            RIGHT:   if (lrck_fall) state_next = LEFT;
            default: state_next = IDLE;
        endcase
    end

    // Channel-start strobes and the FIFO pop request
    always_comb begin
        frame_start = 1'b0;
        right_start = 1'b0;
        case (state)
            IDLE, RIGHT: frame_start = lrck_fall;
            LEFT:        right_start = lrck_rise;
            default:     ;
        endcase
        pop = frame_start && !fifo_empty;
    end

`ifdef AUDIO_DAC_UNDERFLOW_HOLD_EN
    logic [SAMPLE_BITS-1:0] hold_left, hold_right;

    // Remember the last pair actually taken from the FIFO
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hold_left  <= '0;
            hold_right <= '0;
        end else if (clear_audio_out_memory) begin
            hold_left  <= '0;
            hold_right <= '0;
        end else if (pop) begin
            hold_left  <= pop_left;
            hold_right <= pop_right;
        end
    end

    assign empty_left  = hold_left;
    assign empty_right = hold_right;
`else
    assign empty_left  = '0;
    assign empty_right = '0;
`endif

    // Pair loaded at frame start: silence while flushing, fallback on underflow
    always_comb begin
        if (clear_audio_out_memory) begin
            next_left  = '0;
            next_right = '0;
        end else if (fifo_empty) begin
            next_left  = empty_left;
            next_right = empty_right;
        end else begin
            next_left  = pop_left;
            next_right = pop_right;
        end
    end

    // Sticky error flags, cleared by the flush pulse
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear_audio_out_memory) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_audio_out && !audio_out_allowed) overflow  <= 1'b1;
            if (frame_start && fifo_empty)             underflow <= 1'b1;
        end
    end

    // Bit shifter: delay slot, SAMPLE_BITS data bits, then zeros until the next LRCK edge.
    // A flush zeroes the pending right word so the word in flight still completes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            shift_word   <= '0;
            right_word   <= '0;
            bit_cnt      <= '0;
            slot_pending <= 1'b0;
            active       <= 1'b0;
            AUD_DACDAT   <= 1'b0;
        end else begin
            if (frame_start) begin
                shift_word   <= next_left;
                right_word   <= next_right;
                bit_cnt      <= BIT_LOAD;
                slot_pending <= 1'b1;
                active       <= 1'b1;
            end else if (right_start) begin
                shift_word   <= right_word;
                bit_cnt      <= BIT_LOAD;
                slot_pending <= 1'b1;
                active       <= 1'b1;
            end else if (bclk_fall) begin
                if (slot_pending) begin
                    AUD_DACDAT   <= 1'b0;
                    slot_pending <= 1'b0;
                end else if (active) begin
                    AUD_DACDAT <= shift_word[SAMPLE_BITS-1];
                    shift_word <= shift_word << 1;
                    if (bit_cnt == '0) active  <= 1'b0;
                    else               bit_cnt <= bit_cnt - CW'(1);
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end
            if (clear_audio_out_memory) right_word <= '0;
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Scoreboard bench for audio_dac_serializer: stimulus queues expected
// 32-slot channel words, a BCLK-driven monitor collects and compares them.
module tb_audio_dac_serializer;

    localparam int unsigned DW = 32;
    localparam int unsigned FD = 128;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0;
    logic          clear_audio_out_memory = 1'b0;
    logic [DW-1:0] left_in = '0;
    logic [DW-1:0] right_in = '0;
    logic          write_audio_out = 1'b0;
    logic          AUD_BCLK = 1'b0;
    logic          AUD_DACLRCK = 1'b1;
    logic          audio_out_allowed;
    logic [7:0]    fifo_used;
    logic          overflow;
    logic          underflow;
    logic          AUD_DACDAT;

    int total = 0;
    int bad   = 0;

    pair_t       model_q[$];
    logic [31:0] exp_q[$];
    logic [23:0] hold_l = '0;
    logic [23:0] hold_r = '0;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_dac_serializer #(
        .DATA_WIDTH  (32),
        .SAMPLE_BITS (24),
        .FIFO_DEPTH  (FD)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .resetn                  (resetn),
        .clear_audio_out_memory  (clear_audio_out_memory),
        .left_channel_audio_out  (left_in),
        .right_channel_audio_out (right_in),
        .write_audio_out         (write_audio_out),
        .audio_out_allowed       (audio_out_allowed),
        .fifo_used               (fifo_used),
        .overflow                (overflow),
        .underflow               (underflow),
        .AUD_BCLK                (AUD_BCLK),
        .AUD_DACLRCK             (AUD_DACLRCK),
        .AUD_DACDAT              (AUD_DACDAT)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // One channel as seen at 32 BCLK rises: previous tail, delay slot, 24 bits, 6 zeros
    function automatic logic [31:0] pat(input logic [23:0] w);
        return {2'b00, w, 6'b000000};
    endfunction

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r, input bit accept);
        pair_t p;
        @(negedge CLOCK_50);
        left_in = l;
        right_in = r;
        write_audio_out = 1'b1;
        @(negedge CLOCK_50);
        write_audio_out = 1'b0;
        if (accept) begin
            p.l = l[31:8];
            p.r = r[31:8];
            model_q.push_back(p);
        end
    endtask

    task automatic expect_frame(input bit right_zero);
        pair_t p;
        if (model_q.size() == 0) begin
`ifdef AUDIO_DAC_UNDERFLOW_HOLD_EN
            p.l = hold_l;
            p.r = hold_r;
`else
            p.l = '0;
            p.r = '0;
`endif
        end else begin
            p = model_q.pop_front();
            hold_l = p.l;
            hold_r = p.r;
        end
        exp_q.push_back(pat(p.l));
        exp_q.push_back(right_zero ? 32'h0 : pat(p.r));
    endtask

    // Caller starts this on a CLOCK_50 negedge; LRCK changes with the BCLK rise
    task automatic drive_frame();
        for (int unsigned ch = 0; ch < 2; ch++) begin
            for (int unsigned b = 0; b < 32; b++) begin
                AUD_BCLK = 1'b1;
                if (b == 0) AUD_DACLRCK = (ch == 1);
                #160;
                AUD_BCLK = 1'b0;
                #160;
            end
        end
    endtask

    task automatic flush_model();
        model_q.delete();
        hold_l = '0;
        hold_r = '0;
    endtask

    // Monitor: assemble 32 sampled bits per channel and compare against the scoreboard
    initial begin : monitor
        logic [31:0] sh;
        logic [31:0] e;
        int unsigned n;
        sh = '0;
        n = 0;
        forever begin
            @(posedge AUD_BCLK);
            sh = {sh[30:0], AUD_DACDAT};
            n++;
            if (n == 32) begin
                n = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL serial_word: got=%h expected=none", sh);
                end else begin
                    e = exp_q.pop_front();
                    check("serial_word", sh, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned k;

        // Reset behaviour
        repeat (3) @(negedge CLOCK_50);
        check("rst_allowed", audio_out_allowed, 0);
        check("rst_dacdat", AUD_DACDAT, 0);
        check("rst_used", fifo_used, 0);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("rel_allowed", audio_out_allowed, 1);
        check("rel_used", fifo_used, 0);
        check("rel_flags", {overflow, underflow}, 0);

        // Single pair: full-scale negative left, near full-scale positive right
        push_pair(32'h8000_0000, 32'h7FFF_FF00, 1);
        check("one_used", fifo_used, 1);
        expect_frame(0);
        @(negedge CLOCK_50);
        drive_frame();
        repeat (4) @(negedge CLOCK_50);
        check("one_drained", fifo_used, 0);
        check("one_no_uflow", underflow, 0);

        // Fill to capacity, then overflow
        for (int unsigned i = 0; i < FD; i++)
            push_pair({8'h10, 16'(i), 8'h00}, {8'h20, 16'(i), 8'h00}, 1);
        check("full_used", fifo_used, 128);
        check("full_allowed", audio_out_allowed, 0);
        push_pair(32'hDEAD_BE00, 32'hFEED_0000, 0);
        check("ovf_flag", overflow, 1);
        check("ovf_used", fifo_used, 128);

        // One pop from full: allowed returns within 2 cycles
        expect_frame(0);
        @(negedge CLOCK_50);
        fork
            drive_frame();
            begin
                k = 0;
                while (fifo_used != 8'd127 && k < 200) begin
                    @(negedge CLOCK_50);
                    k++;
                end
                check("pop_seen", (k < 200), 1);
                if (!audio_out_allowed) @(negedge CLOCK_50);
                check("pop_allowed", audio_out_allowed, 1);
            end
        join
        check("pop_used", fifo_used, 127);

        // Flush between frames
        @(negedge CLOCK_50);
        clear_audio_out_memory = 1'b1;
        @(negedge CLOCK_50);
        clear_audio_out_memory = 1'b0;
        flush_model();
        check("clr_used", fifo_used, 0);
        check("clr_ovf", overflow, 0);
        check("clr_allowed", audio_out_allowed, 1);

        // Underflow after one known pair
        push_pair(32'h1234_5600, 32'hABCD_EF00, 1);
        expect_frame(0);
        @(negedge CLOCK_50);
        drive_frame();
        repeat (4) @(negedge CLOCK_50);
        check("pre_uflow", underflow, 0);
        expect_frame(0);
        @(negedge CLOCK_50);
        drive_frame();
        repeat (4) @(negedge CLOCK_50);
        check("uflow_flag", underflow, 1);
        check("uflow_used", fifo_used, 0);

        // Push and pop in the same cycle at fifo_used=5
        for (int unsigned i = 0; i < 5; i++)
            push_pair({8'h5A, 16'(i), 8'h00}, {8'hC3, 16'(i), 8'h00}, 1);
        check("five_used", fifo_used, 5);
        expect_frame(0);
        @(negedge CLOCK_50);
        fork
            drive_frame();
            begin
                // LRCK edge detected on the third CLOCK_50 rise after the change
                repeat (2) @(posedge CLOCK_50);
                @(negedge CLOCK_50);
                left_in = 32'h0F0F_0F00;
                right_in = 32'hF0F0_F000;
                write_audio_out = 1'b1;
                @(posedge CLOCK_50);
                #1;
                write_audio_out = 1'b0;
                check("pushpop_used", fifo_used, 5);
                begin
                    pair_t p;
                    p.l = 24'h0F0F0F;
                    p.r = 24'hF0F0F0;
                    model_q.push_back(p);
                end
            end
        join
        repeat (4) @(negedge CLOCK_50);
        check("pushpop_after", fifo_used, 5);

        // Refill, overflow, then flush in the middle of the left word
        for (int unsigned i = 0; i < FD - 5; i++)
            push_pair({8'h33, 16'(i), 8'h00}, {8'h44, 16'(i), 8'h00}, 1);
        check("refill_allowed", audio_out_allowed, 0);
        push_pair(32'h0101_0100, 32'h0202_0200, 0);
        check("pre_clr_flags", {overflow, underflow}, 2'b11);
        expect_frame(1);
        @(negedge CLOCK_50);
        fork
            drive_frame();
            begin
                #(10 * 320);
                @(negedge CLOCK_50);
                clear_audio_out_memory = 1'b1;
                @(negedge CLOCK_50);
                clear_audio_out_memory = 1'b0;
            end
        join
        flush_model();
        repeat (4) @(negedge CLOCK_50);
        check("midclr_used", fifo_used, 0);
        check("midclr_flags", {overflow, underflow}, 0);

        repeat (10) @(negedge CLOCK_50);
        check("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Sink end of the audio-out sample interface.
- Accepts stereo sample pairs from tone/mix logic through a write/allowed handshake and buffers them in a FIFO.
- Serializes the pairs MSB-first onto AUD_DACDAT in I2S format, timed by codec-mastered AUD_BCLK/AUD_DACLRCK.
- Replaces the DAC path of the vendor audio controller in the tone-generator designs.

Parameters:
- DATA_WIDTH, 32, width of each channel sample on the write interface.
- SAMPLE_BITS, 24, bits serialized per channel; taken from the DATA_WIDTH-1 downto DATA_WIDTH-SAMPLE_BITS slice. Must be ≤ DATA_WIDTH.
- FIFO_DEPTH, 128, stereo pairs buffered; power of two, ≥ 4.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- clear_audio_out_memory  in  1  synchronous FIFO flush pulse.
- left_channel_audio_out  in  DATA_WIDTH  left sample, signed.
- right_channel_audio_out  in  DATA_WIDTH  right sample, signed.
- write_audio_out  in  1  push one stereo pair this cycle.
- audio_out_allowed  out  1  FIFO can accept a pair.
- fifo_used  out  $clog2(FIFO_DEPTH)+1  pairs currently stored.
- overflow  out  1  sticky: write attempted while not allowed.
- underflow  out  1  sticky: frame started with FIFO empty.
- AUD_BCLK  in  1  codec bit clock, asynchronous to CLOCK_50.
- AUD_DACLRCK  in  1  codec frame clock; low = left channel.
- AUD_DACDAT  out  1  serial DAC data.

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO empty; fifo_used=0.
  - audio_out_allowed=0 during reset, 1 on the first cycle after release.
  - overflow=0, underflow=0, AUD_DACDAT=0, serializer state IDLE.
- Synchronization: AUD_BCLK and AUD_DACLRCK each pass through a 2-FF synchronizer into CLOCK_50. Edges are detected on the synchronized value; detection latency is 3 CLOCK_50 cycles. Codec BCLK ≤ 3.2 MHz guarantees every edge is seen.
- Write handshake:
  - audio_out_allowed = (fifo_used != FIFO_DEPTH), registered.
  - A pair is pushed on a cycle with write_audio_out=1 and audio_out_allowed=1.
  - write_audio_out=1 while not allowed drops the data and sets overflow.
- Simultaneous push and pop: both take effect; fifo_used is unchanged. Pop has priority for the read pointer; no data is lost.
- clear_audio_out_memory:
  - Pointers and fifo_used go to 0 next cycle. A push on the same cycle is discarded.
  - overflow and underflow are cleared.
  - The serializer finishes the current channel word, then outputs 0 until the next left frame.
- Serializer FSM states: IDLE, LEFT, RIGHT.
  - IDLE→LEFT on a DACLRCK falling edge. The FIFO is popped in the same cycle the edge is detected; the left and right words are latched.
  - LEFT→RIGHT on a DACLRCK rising edge.
  - RIGHT→LEFT on a DACLRCK falling edge, with a new pop.
  - In LEFT/RIGHT, a bit counter reloads to SAMPLE_BITS-1 on the LRCK edge.
  - On each BCLK falling edge the current bit is driven to AUD_DACDAT and the counter decrements. The first falling edge after the LRCK edge is a one-bit I2S delay slot and drives 0; the MSB follows on the next falling edge.
  - After SAMPLE_BITS bits, AUD_DACDAT=0 until the next LRCK edge.
  - An LRCK edge arriving before the word completes truncates it (LSBs lost) with no error.
- Underflow: if the FIFO is empty at the left-frame start, the pair serialized is 0/0, underflow is set, and no pop occurs.
- Width: no arithmetic is performed on samples; the slice is taken verbatim, two's complement preserved.

Optional Feature:
- Macro: AUDIO_DAC_UNDERFLOW_HOLD_EN.
- Defined: on underflow the last successfully popped pair is re-serialized (0/0 if none since reset or clear). The underflow flag still sets.
- Undefined: underflow frames serialize 0/0.

Decomposition:
- Package audio_dac_pkg holds:
  - serializer state enum (IDLE, LEFT, RIGHT);
  - default constants for DATA_WIDTH, SAMPLE_BITS, FIFO_DEPTH;
  - the synchronizer stage count (2).
- Sub-module audio_sample_fifo: synchronous single-clock FIFO, 2*DATA_WIDTH wide, with push/pop/clear and a used count.
- Synchronizers, edge detect and the FSM stay in the top module.

Test Plan:
- Reset → audio_out_allowed=0 and AUD_DACDAT=0 while resetn=0. Release → allowed=1, fifo_used=0.
- Push L=32'h80000000, R=32'h7FFFFF00; drive BCLK 3.072 MHz, LRCK 48 kHz → left frame bits after the delay slot are 1 followed by 23 zeros; right frame is 0 then 23 ones; fifo_used returns to 0.
- Push 128 pairs with no LRCK → allowed=0 at fifo_used=128. Push a 129th → overflow=1, fifo_used stays 128. Next pop → allowed=1 within 2 cycles.
- Empty FIFO at an LRCK falling edge → underflow=1 and 48 zero bits are output. With AUDIO_DAC_UNDERFLOW_HOLD_EN defined, the previous pair 32'h12345600/32'hABCDEF00 is repeated instead.
- Push and pop on the same cycle with fifo_used=5 → fifo_used=5 and the popped data equals the oldest pair.
- Assert clear_audio_out_memory mid-left-word → the left word completes, the right word is all 0, fifo_used=0, and overflow and underflow are cleared.
